data_ram: RTL and testbench
===========================

DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, byte-address width; word depth = 2**(ADDR_WIDTH-2).
REQ-002 SHALL have parameter LATENCY, default 1, wait cycles from accept to response; legal range 1..15.
REQ-003 SHALL have parameter DATA_WIDTH, default 32; only 32 is legal (MIPS word).
REQ-004 i_clk  in  1  single clock, rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  1  access request, sampled when o_ready=1.
REQ-007 i_we  in  1  1=store, 0=load.
REQ-008 i_addr  in  ADDR_WIDTH  byte address.
REQ-009 i_size  in  2  0=byte, 1=halfword, 2=word; 3 reserved, treated as word.
REQ-010 i_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 i_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 o_ready  out  1  module idle, can accept a request.
REQ-013 o_valid  out  1  one-cycle pulse, access complete.
REQ-014 o_data  out  32  load result, right-aligned and extended; valid while o_valid=1.
REQ-015 o_misalign  out  1  qualifies o_valid: access rejected as misaligned.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE; o_ready=1 only in IDLE.
REQ-017 In IDLE with i_req=1, SHALL latch i_we, i_addr, i_size, i_unsigned, i_data and go to WAIT.
REQ-018 WAIT SHALL last exactly LATENCY cycles, counted by a 4-bit down-counter loaded with LATENCY-1.
REQ-019 On WAIT exit SHALL perform the array read or byte-enabled write, then enter DONE.
REQ-020 In DONE SHALL assert o_valid for one cycle and return to IDLE; accept-to-o_valid = LATENCY+1 cycles.
REQ-021 Byte lanes little-endian: byte k of word = bits [8k+7:8k], lane = addr[1:0].
REQ-022 Store byte SHALL write only lane addr[1:0]; halfword SHALL write lanes addr[1]*2 and addr[1]*2+1; word SHALL write all lanes.
REQ-023 Load SHALL shift the selected lanes to bit 0 and extend per i_unsigned; word loads ignore i_unsigned.
REQ-024 o_data SHALL hold its last load value between responses; stores SHALL leave o_data unchanged.
REQ-025 Address bits above depth SHALL NOT exist; the address wraps naturally within 2**ADDR_WIDTH bytes.
REQ-026 i_req while o_ready=0 SHALL be ignored (no queueing).

Reset
REQ-027 Reset asserted SHALL force IDLE, counter 0, o_ready=1, o_valid=0, o_data=0, o_misalign=0 immediately.
REQ-028 Reset mid-access SHALL abort it; a store not yet committed (WAIT) SHALL NOT write the array.
REQ-029 Array contents SHALL NOT be reset.

Configuration
REQ-030 Macro DATA_RAM_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip array access, complete with normal timing, pulse o_valid with o_misalign=1, leave o_data unchanged.
REQ-031 Macro undefined: the low address bits not used by the access size SHALL be forced to 0 (access aligned down), and o_misalign SHALL be tied 0.

Structure
REQ-032 Shared package data_ram_pkg SHALL hold the size encodings (SIZE_BYTE/HALF/WORD) and FSM state typedef.
REQ-033 Sub-module data_ram_lane SHALL hold the lane logic: store byte-enable/data alignment and load extraction/extension, combinational.

Verification
REQ-034 LATENCY=1: store word 0xDEADBEEF @0x010, load word @0x010 -> o_valid 2 cycles after each accept, o_data=0xDEADBEEF.
REQ-035 Store byte 0x80 @0x011, load byte signed @0x011 -> 0xFFFFFF80; unsigned -> 0x00000080; word @0x010 -> 0xDEAD80EF.
REQ-036 Store half 0x1234 @0x012, load half signed @0x012 -> 0x00001234; word @0x010 -> 0x123480EF.
REQ-037 LATENCY=3: i_req held high continuously -> o_ready low 4 cycles per access; extra requests during busy dropped.
REQ-038 Store word @0x014 with reset pulsed during WAIT -> o_ready=1 at once, no o_valid; load @0x014 returns prior contents.
REQ-039 Word load @0x013: with DATA_RAM_MISALIGN_CHECK_EN -> o_valid with o_misalign=1, o_data unchanged; without -> data of word @0x010, o_misalign=0.

Source files
------------

// File: rtl/data_ram_pkg.sv
// data_ram_pkg: access-size encodings, FSM state type and alignment helpers shared by data_ram.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package data_ram_pkg;

    // Access size encodings on i_size; the reserved code behaves as a word access
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Request fields captured at accept time (address is kept separately, its width is a parameter)
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] data;
    } req_t;

    // Fold the reserved size code onto word so downstream logic sees only three sizes
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SIZE_RSVD) ? SIZE_WORD : size;
    endfunction

    // True when the low address bits are not aligned to the access size
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_HALF: mis = lo[0];
            SIZE_WORD: mis = |lo;
            SIZE_RSVD: mis = |lo;
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Clear the low address bits the access size does not use (align down)
    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        logic [1:0] al;
        al = lo;
        case (size)
            SIZE_HALF: al = {lo[1], 1'b0};
            SIZE_WORD: al = 2'b00;
            SIZE_RSVD: al = 2'b00;
            default:   al = lo;
        endcase
        return al;
    endfunction

endpackage

// File: rtl/data_ram_lane.sv
// data_ram_lane: little-endian byte-lane steering for stores and extraction/extension for loads.
// Latency: purely combinational.
// Backpressure: none; follows the latched request of the parent.
module data_ram_lane
    import data_ram_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Store side: replicate the right-aligned data across lanes and enable only the addressed ones
    always_comb begin
        byte_en = 4'b1111;
        wr_word = st_data;
        case (size)
            SIZE_BYTE: begin
                byte_en = 4'b0001 << lane;
                wr_word = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{st_data[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_word = st_data;
            end
        endcase
    end

    // Load side: pick the addressed lanes of the array word
    always_comb begin
        sel_byte = rd_word[7:0];
        case (lane)
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Load side: right-align and sign/zero extend; word loads pass through unchanged
    always_comb begin
        ld_data = rd_word;
        case (size)
            SIZE_BYTE: ld_data = {{24{sel_byte[7] & ~is_unsigned}}, sel_byte};
            SIZE_HALF: ld_data = {{16{sel_half[15] & ~is_unsigned}}, sel_half};
            default:   ld_data = rd_word;
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// data_ram: single-port byte/half/word data memory with a fixed, parameterised access latency.
// Latency: a request accepted in IDLE yields a one-cycle o_valid LATENCY+1 cycles later; one access in flight.
// Backpressure: o_ready is low while busy; requests presented while busy are dropped, never queued.
// Option: define DATA_RAM_MISALIGN_CHECK_EN to reject misaligned half/word accesses with o_misalign;
// without it, misaligned addresses are silently aligned down. LATENCY legal range is 1..15,
// DATA_WIDTH must be 32.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_misalign
);

    localparam int         DEPTH    = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                state;
    logic [3:0]            cnt;
    req_t                  req_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [31:0]           rd_word;
    logic [1:0]            lane;
    logic                  acc_mis;
    logic                  wait_exit;

    logic [3:0]            byte_en;
    logic [31:0]           wr_word;
    logic [31:0]           ld_data;

    // The array access happens on the final WAIT cycle, using only latched request fields
    assign wait_exit = (state == ST_WAIT) && (cnt == 4'd0);
    assign word_idx  = addr_q[ADDR_WIDTH-1:2];
    assign rd_word   = mem[word_idx];

`ifdef DATA_RAM_MISALIGN_CHECK_EN
    assign acc_mis = is_misaligned(req_q.size, addr_q[1:0]);
    assign lane    = addr_q[1:0];

    // o_misalign qualifies the single o_valid cycle and drops with it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_misalign <= 1'b0;
        end else begin
            o_misalign <= wait_exit & acc_mis;
        end
    end
`else
    // Misaligned accesses are aligned down, so rejection never happens
    assign acc_mis    = 1'b0;
    assign lane       = align_lo(req_q.size, addr_q[1:0]);
    assign o_misalign = 1'b0;
`endif

    data_ram_lane u_lane (
        .size        (req_q.size),
        .lane        (lane),
        .is_unsigned (req_q.is_unsigned),
        .st_data     (req_q.data),
        .rd_word     (rd_word),
        .byte_en     (byte_en),
        .wr_word     (wr_word),
        .ld_data     (ld_data)
    );

    // Access sequencer: IDLE accepts, WAIT counts LATENCY cycles, DONE pulses o_valid
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            req_q   <= '0;
            addr_q  <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        req_q.we          <= i_we;
                        req_q.size        <= norm_size(i_size);
                        req_q.is_unsigned <= i_unsigned;
                        req_q.data        <= i_data;
                        addr_q            <= i_addr;
                        cnt               <= CNT_LOAD;
                        state             <= ST_WAIT;
                        o_ready           <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state   <= ST_DONE;
                        o_valid <= 1'b1;
                        // Stores and rejected accesses leave the last load result in place
                        if (!req_q.we && !acc_mis) begin
                            o_data <= ld_data;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

    // Byte-enabled store commit; the array has no reset so its contents survive i_rst_n
    always_ff @(posedge i_clk) begin
        if (wait_exit && req_q.we && !acc_mis) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_word[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: two data_ram instances (LATENCY 1 and 3) checked against a byte-image memory model.
// Latency: the model predicts o_valid LATENCY edges after accept and o_ready LATENCY+1 edges after.
// Backpressure: random requests arrive regardless of o_ready; the model drops those seen while busy.
module tb_data_ram;

    localparam int AW = 10;
`ifdef DATA_RAM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]         req;
    logic [1:0]         we;
    logic [1:0][AW-1:0] addr;
    logic [1:0][1:0]    size;
    logic [1:0]         uns;
    logic [1:0][31:0]   wdat;
    logic [1:0]         rdy;
    logic [1:0]         vld;
    logic [1:0][31:0]   rdat;
    logic [1:0]         mis;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %08h expected %08h at %0t", nm, k, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        data_ram #(.ADDR_WIDTH(AW), .LATENCY(LAT), .DATA_WIDTH(32)) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_req      (req[g]),
            .i_we       (we[g]),
            .i_addr     (addr[g]),
            .i_size     (size[g]),
            .i_unsigned (uns[g]),
            .i_data     (wdat[g]),
            .o_ready    (rdy[g]),
            .o_valid    (vld[g]),
            .o_data     (rdat[g]),
            .o_misalign (mis[g])
        );

        // Reference: a flat byte image plus "edges left until idle" for the one access in flight
        logic [7:0]  img [1 << AW];
        int          busy_left;
        logic        e_vld;
        logic        e_mis;
        logic [31:0] e_dat;
        logic        p_we;
        logic        p_uns;
        logic [1:0]  p_size;
        logic [AW-1:0] p_addr;
        logic [31:0] p_wd;

        initial begin
            int n;
            int base;
            logic [31:0] v;
            busy_left = 0;
            e_vld = 1'b0; e_mis = 1'b0; e_dat = 32'h0;
            p_we = 1'b0; p_uns = 1'b0; p_size = 2'd0; p_addr = '0; p_wd = 32'h0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    busy_left = 0;
                    e_vld = 1'b0; e_mis = 1'b0; e_dat = 32'h0;
                end else if (busy_left == 0) begin
                    e_vld = 1'b0; e_mis = 1'b0;
                    if (req[g]) begin
                        p_we = we[g]; p_uns = uns[g]; p_size = size[g];
                        p_addr = addr[g]; p_wd = wdat[g];
                        busy_left = LAT + 1;
                    end
                end else begin
                    busy_left--;
                    e_vld = (busy_left == 1);
                    e_mis = 1'b0;
                    if (busy_left == 1) begin
                        n = (p_size == 2'd0) ? 1 : (p_size == 2'd1) ? 2 : 4;
                        base = int'(p_addr);
                        if (MIS_EN && (base % n) != 0) begin
                            e_mis = 1'b1;
                        end else begin
                            base = base - (base % n);
                            if (p_we) begin
                                for (int i = 0; i < n; i++) img[base + i] = p_wd[8*i +: 8];
                            end else begin
                                v = 32'h0;
                                for (int i = 0; i < n; i++) v[8*i +: 8] = img[base + i];
                                if (!p_uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                                e_dat = v;
                            end
                        end
                    end
                end
            end
        end

        // Every cycle, all four outputs must agree with the reference
        initial begin
            forever begin
                @(negedge clk);
                chk("ready", g, rdy[g], busy_left == 0);
                chk("valid", g, vld[g], e_vld);
                chk("misalign", g, mis[g], e_mis);
                chk("data", g, rdat[g], e_dat);
            end
        end
    end

    task automatic access(input int k, input logic w, input logic [AW-1:0] a, input logic [1:0] s,
                          input logic u, input logic [31:0] d,
                          output logic [31:0] rd, output logic rm, output int lat);
        int guard;
        guard = 0;
        while (rdy[k] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req[k] = 1'b1; we[k] = w; addr[k] = a; size[k] = s; uns[k] = u; wdat[k] = d;
        @(posedge clk); #1;
        req[k] = 1'b0;
        lat = 1;
        while (vld[k] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdat[k];
        rm = mis[k];
    endtask

    task automatic acc_chk(input string nm, input int k, input int lat_exp, input logic w,
                           input logic [AW-1:0] a, input logic [1:0] s, input logic u,
                           input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_mis);
        logic [31:0] rd;
        logic rm;
        int lat;
        access(k, w, a, s, u, d, rd, rm, lat);
        chk({nm, ".latency"}, k, lat, lat_exp);
        chk({nm, ".data"}, k, rd, exp_rd);
        chk({nm, ".misalign"}, k, rm, exp_mis);
    endtask

    // Fill the two address windows used later so every load hits known contents
    task automatic init_region(input int k);
        logic [31:0] rd;
        logic rm;
        int lat;
        logic [AW-1:0] a;
        for (int i = 0; i < 16; i++) begin
            a = AW'(4 * i);
            access(k, 1'b1, a, 2'd2, 1'b0, 32'hC0DE_0000 | 32'(a), rd, rm, lat);
            a = AW'(10'h3C0 + 4 * i);
            access(k, 1'b1, a, 2'd2, 1'b0, 32'hC0DE_0000 | 32'(a), rd, rm, lat);
        end
    endtask

    task automatic rand_drive(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            req[k]  = ($urandom_range(0, 2) == 0);
            we[k]   = 1'($urandom_range(0, 1));
            addr[k] = (($urandom_range(0, 1) == 1) ? 10'h3C0 : 10'h000) + AW'($urandom_range(0, 63));
            size[k] = 2'($urandom_range(0, 3));
            uns[k]  = 1'($urandom_range(0, 1));
            wdat[k] = $urandom;
        end
        req[k] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int run;
        int runs;
        int pulses;
        int guard;
        req = '0; we = '0; addr = '0; size = '0; uns = '0; wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset.ready", k, rdy[k], 1);
            chk("reset.valid", k, vld[k], 0);
            chk("reset.data", k, rdat[k], 0);
            chk("reset.misalign", k, mis[k], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        init_region(0);
        init_region(1);

        // LATENCY=1 directed accesses with hand-computed results
        acc_chk("st_word",  0, 2, 1'b1, 10'h010, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        acc_chk("ld_word",  0, 2, 1'b0, 10'h010, 2'd2, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0);
        acc_chk("st_byte",  0, 2, 1'b1, 10'h011, 2'd0, 1'b0, 32'h0000_0080, 32'hDEAD_BEEF, 1'b0);
        acc_chk("ld_byte_s",0, 2, 1'b0, 10'h011, 2'd0, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b0);
        acc_chk("ld_byte_u",0, 2, 1'b0, 10'h011, 2'd0, 1'b1, 32'h0,        32'h0000_0080, 1'b0);
        acc_chk("ld_word2", 0, 2, 1'b0, 10'h010, 2'd2, 1'b0, 32'h0,        32'hDEAD_80EF, 1'b0);
        acc_chk("st_half",  0, 2, 1'b1, 10'h012, 2'd1, 1'b0, 32'h0000_1234, 32'hDEAD_80EF, 1'b0);
        acc_chk("ld_half_s",0, 2, 1'b0, 10'h012, 2'd1, 1'b0, 32'h0,        32'h0000_1234, 1'b0);
        acc_chk("ld_word3", 0, 2, 1'b0, 10'h010, 2'd2, 1'b0, 32'h0,        32'h1234_80EF, 1'b0);
        acc_chk("ld_mis",   0, 2, 1'b0, 10'h013, 2'd2, 1'b0, 32'h0,        32'h1234_80EF, MIS_EN);
        acc_chk("st_half2", 0, 2, 1'b1, 10'h01A, 2'd1, 1'b0, 32'hFFFF_8001, 32'h1234_80EF, 1'b0);
        acc_chk("ld_half_n",0, 2, 1'b0, 10'h01A, 2'd1, 1'b0, 32'h0,        32'hFFFF_8001, 1'b0);
        acc_chk("ld_half_u",0, 2, 1'b0, 10'h01A, 2'd1, 1'b1, 32'h0,        32'h0000_8001, 1'b0);
        acc_chk("ld_word4", 0, 2, 1'b0, 10'h018, 2'd2, 1'b0, 32'h0,        32'h8001_0018, 1'b0);

        // Reset during WAIT aborts the store
        guard = 0;
        while (rdy[0] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 10'h014; size[0] = 2'd2; wdat[0] = 32'h5555_AAAA;
        @(posedge clk); #1;
        req[0] = 1'b0;
        chk("abort.busy", 0, rdy[0], 0);
        rst_n = 1'b0;
        #1;
        chk("abort.ready", 0, rdy[0], 1);
        chk("abort.valid", 0, vld[0], 0);
        chk("abort.data", 0, rdat[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_chk("abort.load", 0, 2, 1'b0, 10'h014, 2'd2, 1'b0, 32'h0, 32'hC0DE_0014, 1'b0);

        // LATENCY=3 with i_req held high: 4 busy cycles per access, extra requests dropped
        guard = 0;
        while (rdy[1] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h3C4; size[1] = 2'd2; uns[1] = 1'b0;
        run = 0; runs = 0; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (vld[1] === 1'b1) pulses++;
            if (rdy[1] !== 1'b1) begin
                run++;
            end else if (run > 0) begin
                chk("hold.busy_len", 1, run, 4);
                runs++;
                run = 0;
            end
        end
        req[1] = 1'b0;
        chk("hold.runs", 1, runs, 8);
        chk("hold.pulses", 1, pulses, 8);
        chk("hold.data", 1, rdat[1], 32'hC0DE_03C4);

        // Random traffic on both instances, requests arriving regardless of o_ready
        fork
            rand_drive(0, 1500);
            rand_drive(1, 1500);
        join
        repeat (10) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
